// File: rtl/perm_ctrl_pkg.sv
// Shared types and constants for the lane-permutation sequencer.
package perm_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_PERMUTE = 3'd2,
    ST_LOAD    = 3'd3,
    ST_EMIT    = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  localparam int unsigned DEFAULT_DEPTH = 64;
  localparam int unsigned LANE_W        = 25;

endpackage

// File: rtl/perm_word_counter.sv
// Word index counter: clear to 0, increment, and terminal flag at DEPTH-1.
module perm_word_counter #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [IDX_W-1:0] count_o,
  output logic             term_o
);

  logic [IDX_W-1:0] count_q, count_d;

  assign term_o  = (count_q == IDX_W'(DEPTH - 1));
  assign count_o = count_q;

  // Saturate at the terminal value; the index never wraps.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && !term_o) begin
      count_d = count_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/perm_seq_ctrl.sv
// Sequencer for the lane-permutation datapath: fetch, permute, load, emit per word.
//
// state   | meaning
// IDLE    | waiting for start, all strobes low
// FETCH   | in_ready high, waiting for in_valid
// PERMUTE | one-cycle perm_en strobe
// LOAD    | one-cycle ld strobe
// EMIT    | out_valid held until out_ready
// DONE    | one-cycle done pulse after the last word
module perm_seq_ctrl
  import perm_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic             perm_en_o,
  output logic             ld_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [IDX_W-1:0] word_idx_o,
  output logic             busy_o,
  output logic             done_o
);

  state_e state_q, state_d;
  logic   idx_clr, idx_inc, idx_term;

  assign idx_clr = (state_q == ST_IDLE) && start_i && !abort_i;
  assign idx_inc = (state_q == ST_EMIT) && out_ready_i && !abort_i;

  perm_word_counter #(
    .DEPTH(DEPTH),
    .IDX_W(IDX_W)
  ) u_word_counter (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (idx_clr),
    .inc_i  (idx_inc),
    .count_o(word_idx_o),
    .term_o (idx_term)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // abort wins over any handshake completing in the same cycle.
  always_comb begin
    state_d = state_q;
    if (state_q != ST_IDLE && abort_i) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:    if (start_i && !abort_i) state_d = ST_FETCH;
        ST_FETCH:   if (in_valid_i) state_d = ST_PERMUTE;
        ST_PERMUTE: state_d = ST_LOAD;
        ST_LOAD:    state_d = ST_EMIT;
        ST_EMIT:    if (out_ready_i) state_d = idx_term ? ST_DONE : ST_FETCH;
        ST_DONE:    state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready_o  = (state_q == ST_FETCH);
    perm_en_o   = (state_q == ST_PERMUTE);
    ld_o        = (state_q == ST_LOAD);
    out_valid_o = (state_q == ST_EMIT);
    done_o      = (state_q == ST_DONE);
    busy_o      = (state_q != ST_IDLE);
  end

endmodule

// File: doc/perm_seq_ctrl.md
# perm_seq_ctrl

Sequencer for the 25-bit lane-permutation datapath. Fetches DEPTH input words one at a time over a valid/ready handshake, strobes the datapath's permute step and output-register load, and presents each result over a valid/ready handshake. Signals completion once all DEPTH words are processed. Sits between the word source/sink and the permutation datapath. Replaces the free-running depth counter with an explicit FSM.

## Interface

- DEPTH, 64: words per run; DEPTH >= 2.
- IDX_W, 6: index width, equals $clog2(DEPTH).
- clk  in  1  rising-edge clock (one clock domain).
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin a run; sampled only in IDLE.
- abort  in  1  synchronous cancel; honoured in every state except IDLE.
- in_valid  in  1  source has a word on the datapath input.
- in_ready  out  1  controller accepts the input word this cycle.
- perm_en  out  1  one-cycle strobe: datapath computes the permutation.
- ld  out  1  one-cycle strobe: datapath output register loads.
- out_valid  out  1  result in output register is valid.
- out_ready  in  1  sink takes the result.
- word_idx  out  IDX_W  index of the word in flight, 0..DEPTH-1.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last word is consumed.

## Operation

- States: IDLE, FETCH, PERMUTE, LOAD, EMIT, DONE.
- IDLE: all strobes 0. When start=1 and abort=0, go to FETCH and set word_idx=0. start=1 with abort=1 stays in IDLE.
- FETCH: in_ready=1. When in_valid=1, the input handshake completes and the FSM goes to PERMUTE. Otherwise it waits indefinitely.
- PERMUTE: perm_en=1 for exactly this cycle, then LOAD.
- LOAD: ld=1 for exactly this cycle, then EMIT.
- EMIT: out_valid=1, held stable until out_ready=1. On the handshake:
  - If word_idx==DEPTH-1, go to DONE.
  - Otherwise increment word_idx and go to FETCH.
- DONE: done=1 for one cycle, then IDLE. word_idx holds DEPTH-1 until the next start.
- abort=1 in FETCH/PERMUTE/LOAD/EMIT/DONE: go to IDLE next cycle.
  - No done pulse.
  - word_idx is left unchanged.
  - abort overrides any handshake that would otherwise complete in that same cycle.
- start while busy: ignored.
- word_idx never wraps. It is only reset to 0 by start or reset.
- Reset, including mid-run: state=IDLE; word_idx, in_ready, perm_en, ld, out_valid, busy and done all 0.

## Timing

- All outputs are decoded from registered state (Moore). There is no combinational path from any input to any output.
- Start: start high at edge N gives busy=1 and in_ready=1 from edge N+1.
- Per-word latency: input handshake at edge T gives perm_en in cycle T+1, ld in T+2, and out_valid from T+3.
- Per-word throughput: minimum 4 cycles (FETCH, PERMUTE, LOAD, EMIT) with in_valid and out_ready both held high.
- Full run with no stalls: 4·DEPTH + 1 cycles from the first FETCH to the end of the done pulse (256 + 1 for DEPTH=64).
- Back-pressure: out_valid stays high and word_idx stays stable for any number of cycles with out_ready=0.
- Reset assertion takes effect immediately (asynchronous). Deassertion is consumed at the next clk edge.

## Structure

- Package perm_ctrl_pkg holds:
  - the state enumeration (3-bit encoding);
  - default DEPTH = 64;
  - lane word width constant = 25.
- One sub-module, perm_word_counter: IDX_W-bit counter with clear, increment and a terminal flag (count == DEPTH-1). The FSM instantiates it for word_idx.
- The FSM and output decode stay in perm_seq_ctrl.

## Test plan

- Reset/idle: assert rst=0 mid-EMIT with word_idx=17 -> all outputs 0 immediately; after release, state IDLE and nothing moves until start.
- Full run, no stalls, DEPTH=64, in_valid=out_ready=1: exactly 64 perm_en and 64 ld pulses; done is high once, at cycle 257 after the first FETCH; word_idx ends at 63.
- Back-pressure: out_ready=0 for 10 cycles at word_idx=5 -> out_valid held for 10 cycles, word_idx=5 throughout, no extra ld pulse.
- Input starvation: in_valid=0 for 7 cycles in FETCH -> in_ready held high, no perm_en pulse, then normal progress once in_valid=1.
- Abort plus simultaneous events: abort in the same cycle as the EMIT handshake at word_idx=63 -> IDLE next cycle with no done pulse; start and abort together in IDLE -> stays IDLE.
- Start while busy: start pulsed at word_idx=3 -> ignored; the run completes all 64 words and done pulses exactly once.
